id_operand_stage: RTL and testbench
===================================

Name: id_operand_stage

Overview:
- Decode-side operand stage of the RV32I 5-stage pipeline; sits between the IF/ID instruction register and the EX stage.
- Extracts rs1/rs2 from the incoming instruction and drives the read port of `regs`, which has a synchronous read: data is valid one cycle after the address is sampled.
- Bypasses writeback results that `regs` cannot yet reflect.
- Presents {pc, instr, rs1 data, rs2 data} to EX through a valid/ready slot, with stall hold and flush.

Parameters:
XLEN, 32, data/pc width
REG_AW, 5, register index width

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept this cycle
in_pc  in  XLEN  instruction pc
in_instr  in  32  instruction word
flush  in  1  synchronous kill of the accepted or held instruction
rs_rd_en  out  1  to `regs`
rs1  out  REG_AW  to `regs`; in_instr[19:15]
rs2  out  REG_AW  to `regs`; in_instr[24:20]
rs1_rd_data  in  XLEN  from `regs`, valid the cycle after the read
rs2_rd_data  in  XLEN  from `regs`
wb_rd  in  REG_AW  writeback destination, same net as `regs` rd
wb_rd_wr_en  in  1  writeback enable
wb_rd_wr_data  in  XLEN  writeback data
out_valid  out  1  to EX
out_ready  in  1  EX accepts
out_pc  out  XLEN  registered pc
out_instr  out  32  registered instr
out_rs1_data  out  XLEN  operand 1
out_rs2_data  out  XLEN  operand 2

Behaviour:
- States: EMPTY, LIVE, HELD.
- Reset (rst low, async): state EMPTY; out_valid=0; out_pc, out_instr, held operands and bypass-pending regs all 0.
- rs1 and rs2 are always combinational fields of in_instr.
- rs_rd_en = in_valid & in_ready.
- Accept happens when in_valid & in_ready at a posedge: capture pc/instr and source indices; next state is LIVE.
- in_ready:
  - EMPTY: !flush.
  - LIVE/HELD: out_ready & !flush.
- EMPTY: out_valid=0. Accept → LIVE.
- LIVE: the cycle after accept. out_valid=1. Operands come combinationally from rs*_rd_data through the bypass mux.
  - out_ready & accept → LIVE.
  - out_ready & !accept → EMPTY.
  - !out_ready → capture the muxed operands into held regs → HELD.
- HELD: out_valid=1; operands come from held regs. rs_rd_en=0 unless accepting.
  - out_ready & accept → LIVE.
  - out_ready only → EMPTY.
  - Otherwise stay HELD.
- Bypass, per operand, in priority order:
  1. Source index 0 → 0, always.
  2. Current-cycle writeback (wb_rd_wr_en, wb_rd==src) → wb_rd_wr_data. Applies in LIVE and HELD.
  3. Accept-cycle writeback (registered at the accept edge when wb matched src) → registered data. Read-during-write of `regs` is not relied upon.
  4. Otherwise rs*_rd_data (LIVE) or held reg (HELD).
- HELD snoop: a writeback to a held source index (≠0) updates that held operand at the posedge, so the held value never goes stale.
- Flush: out_valid=0 the cycle after; next state EMPTY; no accept in the flush cycle (in_ready=0). Flush beats out_ready.
- out_valid stays high with stable pc/instr until handshaken. Operands may change while HELD only via the writeback snoop.
- Throughput: 1 instruction/cycle with out_ready=1. Latency: accept edge → out_valid next cycle.
- Reset mid-operation: the instruction is dropped; out_valid goes to 0 immediately (async).

Decomposition:
- Shared package rv32i_pkg holds:
  - RS1_MSB/LSB, RS2_MSB/LSB, RD_MSB/LSB field constants.
  - XLEN and REG_AW.
  - The op_state_e enum {EMPTY, LIVE, HELD}.
- One natural sub-module, operand_bypass, instantiated twice. It implements the per-operand priority mux plus the accept-cycle pending register and the held register with snoop.

Test Plan:
- After reset, write x5=0x1234_5678 via `regs`. Issue add x1,x5,x0 with out_ready=1 → out_valid next cycle, out_rs1_data=0x12345678, out_rs2_data=0.
- Back-to-back 4 instructions, out_ready=1 → in_ready constantly 1, out_valid high 4 consecutive cycles, pcs in order 0x0,0x4,0x8,0xC.
- Accept rs1=x7 in the same cycle WB writes x7=0xDEAD_BEEF → out_rs1_data=0xDEADBEEF, not the stale `regs` value.
- out_ready=0 for 3 cycles with rs2=x9 held, WB writes x9=0xA5A5_0001 in the 2nd cycle → out_rs2_data becomes 0xA5A50001, out_pc/out_instr unchanged, in_ready=0 throughout.
- WB writes x0=0xFFFF_FFFF while rs1=x0 → out_rs1_data=0.
- flush asserted in HELD together with in_valid=1 → next cycle out_valid=0, new instruction not accepted (rs_rd_en=0). Deassert rst mid-HELD → out_valid=0 immediately.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I widths, instruction field positions and operand-stage states.
package rv32i_pkg;
   localparam int XLEN    = 32;
   localparam int REG_AW  = 5;
   localparam int RS1_MSB = 19;
   localparam int RS1_LSB = 15;
   localparam int RS2_MSB = 24;
   localparam int RS2_LSB = 20;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 7;
   typedef enum logic [1:0] {EMPTY, LIVE, HELD} op_state_e;
endpackage

// File: rtl/operand_bypass.sv
// operand_bypass: per-operand x0/writeback/accept-cycle bypass mux with a snooping held register.
module operand_bypass
   import rv32i_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              accept,
   input  logic [REG_AW-1:0] src_in,
   input  logic              live,
   input  logic              hold_cap,
   input  logic              hold,
   input  logic [XLEN-1:0]   rd_data,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_en,
   input  logic [XLEN-1:0]   wb_data,
   output logic [XLEN-1:0]   operand
);
   logic [REG_AW-1:0] src;
   logic              pend_v;
   logic [XLEN-1:0]   pend_data;
   logic [XLEN-1:0]   held_data;
   logic              wb_hit;
   assign wb_hit = wb_en && (wb_rd == src);
   // regs read-during-write is not trusted, so an accept-edge writeback is remembered here
   always_comb operand = (src == '0) ? '0 :
                         wb_hit      ? wb_data :
                         (live && pend_v) ? pend_data :
                         live        ? rd_data : held_data;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         src       <= '0;
         pend_v    <= 1'b0;
         pend_data <= '0;
         held_data <= '0;
      end else begin
         if (accept) begin
            src       <= src_in;
            pend_v    <= wb_en && (wb_rd == src_in);
            pend_data <= wb_data;
         end
         if (hold_cap)
            held_data <= operand;
         else if (hold && wb_hit)
            held_data <= wb_data;
      end
   end
endmodule

// File: rtl/id_operand_stage.sv
// id_operand_stage: decode-side operand fetch with writeback bypass and a valid/ready slot to EX.
module id_operand_stage
   import rv32i_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [31:0]       in_instr,
   input  logic              flush,
   output logic              rs_rd_en,
   output logic [REG_AW-1:0] rs1,
   output logic [REG_AW-1:0] rs2,
   input  logic [XLEN-1:0]   rs1_rd_data,
   input  logic [XLEN-1:0]   rs2_rd_data,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_rd_wr_en,
   input  logic [XLEN-1:0]   wb_rd_wr_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_pc,
   output logic [31:0]       out_instr,
   output logic [XLEN-1:0]   out_rs1_data,
   output logic [XLEN-1:0]   out_rs2_data
);
   op_state_e state, state_nxt;
   logic      accept;
   logic      live;
   logic      hold;
   logic      hold_cap;
   assign rs1 = in_instr[RS1_MSB:RS1_LSB];
   assign rs2 = in_instr[RS2_MSB:RS2_LSB];
   always_comb begin
      in_ready  = (state == EMPTY) ? !flush : (out_ready && !flush);
      accept    = in_valid && in_ready;
      rs_rd_en  = accept;
      out_valid = (state != EMPTY);
      live      = (state == LIVE);
      hold      = (state == HELD);
      hold_cap  = live && !out_ready;
      state_nxt = flush ? EMPTY :
                  accept ? LIVE :
                  (state != EMPTY && out_ready) ? EMPTY :
                  live ? HELD : state;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= EMPTY;
         out_pc    <= '0;
         out_instr <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            out_pc    <= in_pc;
            out_instr <= in_instr;
         end
      end
   end
   operand_bypass u_byp1 (
      .clk(clk), .rst(rst), .accept(accept), .src_in(rs1), .live(live),
      .hold_cap(hold_cap), .hold(hold), .rd_data(rs1_rd_data), .wb_rd(wb_rd),
      .wb_en(wb_rd_wr_en), .wb_data(wb_rd_wr_data), .operand(out_rs1_data)
   );
   operand_bypass u_byp2 (
      .clk(clk), .rst(rst), .accept(accept), .src_in(rs2), .live(live),
      .hold_cap(hold_cap), .hold(hold), .rd_data(rs2_rd_data), .wb_rd(wb_rd),
      .wb_en(wb_rd_wr_en), .wb_data(wb_rd_wr_data), .operand(out_rs2_data)
   );
endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage: scoreboard bench; operands must equal the architectural register value each valid cycle.
module tb_id_operand_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0, in_ready, flush = 1'b0, rs_rd_en;
   logic [31:0] in_pc = '0, in_instr = '0;
   logic [4:0]  rs1, rs2, wb_rd = '0;
   logic [31:0] rs1_rd_data = '0, rs2_rd_data = '0, wb_rd_wr_data = '0;
   logic        wb_rd_wr_en = 1'b0, out_valid, out_ready = 1'b1;
   logic [31:0] out_pc, out_instr, out_rs1_data, out_rs2_data;
   typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
   ent_t        q[$];
   logic [31:0] mem[32];
   logic [31:0] arch[32];
   int          total = 0, bad = 0;

   id_operand_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
      .in_instr(in_instr), .flush(flush), .rs_rd_en(rs_rd_en), .rs1(rs1), .rs2(rs2),
      .rs1_rd_data(rs1_rd_data), .rs2_rd_data(rs2_rd_data), .wb_rd(wb_rd),
      .wb_rd_wr_en(wb_rd_wr_en), .wb_rd_wr_data(wb_rd_wr_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
      .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
      end
   endfunction

   function automatic logic [31:0] arch_val(input logic [4:0] s);
      if (s == 5'd0) return 32'd0;
      if (wb_rd_wr_en && wb_rd == s) return wb_rd_wr_data;
      return arch[s];
   endfunction

   function automatic logic [31:0] mk(input int rd, input int s1, input int s2);
      return {7'd0, s2[4:0], s1[4:0], 3'd0, rd[4:0], 7'h33};
   endfunction

   // naive register file: synchronous read of the pre-write value, and it even stores x0
   always @(posedge clk) begin
      if (rs_rd_en) begin
         rs1_rd_data <= mem[rs1];
         rs2_rd_data <= mem[rs2];
      end
      if (wb_rd_wr_en) mem[wb_rd] <= wb_rd_wr_data;
   end

   always @(negedge clk) begin
      logic exp_rdy;
      if (!rst) begin
         q.delete();
         chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
         exp_rdy = !flush && (q.size() == 0 || out_ready);
         chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
         chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
         chk("rs_rd_en", {31'd0, rs_rd_en}, {31'd0, in_valid && exp_rdy});
         chk("rs1_idx", {27'd0, rs1}, {27'd0, in_instr[19:15]});
         chk("rs2_idx", {27'd0, rs2}, {27'd0, in_instr[24:20]});
         if (q.size() != 0) begin
            chk("out_pc", out_pc, q[0].pc);
            chk("out_instr", out_instr, q[0].instr);
            chk("out_rs1_data", out_rs1_data, arch_val(q[0].instr[19:15]));
            chk("out_rs2_data", out_rs2_data, arch_val(q[0].instr[24:20]));
            if (flush || out_ready) void'(q.pop_front());
         end
         if (in_valid && exp_rdy) q.push_back('{pc: in_pc, instr: in_instr});
         if (wb_rd_wr_en && wb_rd != 5'd0) arch[wb_rd] = wb_rd_wr_data;
      end
   end

   task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic ordy, input logic fl, input logic we,
                      input logic [4:0] wrd, input logic [31:0] wd);
      @(posedge clk);
      #1;
      in_valid = v; in_pc = pc; in_instr = ins; out_ready = ordy; flush = fl;
      wb_rd_wr_en = we; wb_rd = wrd; wb_rd_wr_data = wd;
   endtask

   task automatic idle();
      cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         mem[i]  = $urandom;
         arch[i] = mem[i];
      end
      mem[0]  = 32'hBAD0_0000;
      arch[0] = 32'd0;
      #2;
      chk("reset_out_pc", out_pc, 32'd0);
      chk("reset_out_instr", out_instr, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      // x5 written via regs, then read by add x1,x5,x0
      cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h1234_5678);
      cyc(1'b1, 32'h100, mk(1, 5, 0), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      idle();
      @(negedge clk);
      chk("t1_valid", {31'd0, out_valid}, 32'd1);
      chk("t1_rs1", out_rs1_data, 32'h1234_5678);
      chk("t1_rs2", out_rs2_data, 32'd0);
      // back-to-back
      for (int i = 0; i < 4; i++) cyc(1'b1, 32'(i * 4), mk(i + 1, i + 2, i + 3), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      idle();
      @(negedge clk);
      chk("t2_last_pc", out_pc, 32'hC);
      idle();
      // accept-cycle writeback to x7
      cyc(1'b1, 32'h180, mk(2, 7, 0), 1'b1, 1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF);
      idle();
      @(negedge clk);
      chk("t3_rs1", out_rs1_data, 32'hDEAD_BEEF);
      // held with snoop on x9
      cyc(1'b1, 32'h200, mk(2, 3, 9), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      cyc(1'b1, 32'h204, mk(4, 4, 4), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      cyc(1'b1, 32'h208, mk(4, 4, 4), 1'b0, 1'b0, 1'b1, 5'd9, 32'hA5A5_0001);
      cyc(1'b1, 32'h20C, mk(4, 4, 4), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("t4_rs2", out_rs2_data, 32'hA5A5_0001);
      chk("t4_pc", out_pc, 32'h200);
      chk("t4_in_ready", {31'd0, in_ready}, 32'd0);
      idle();
      // x0 writeback must never be visible
      cyc(1'b1, 32'h300, mk(3, 0, 0), 1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
      cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
      @(negedge clk);
      chk("t5_rs1", out_rs1_data, 32'd0);
      // flush while HELD with a competing in_valid
      cyc(1'b1, 32'h400, mk(1, 2, 3), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      cyc(1'b1, 32'h404, mk(1, 2, 3), 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("t6_rs_rd_en", {31'd0, rs_rd_en}, 32'd0);
      idle();
      @(negedge clk);
      chk("t6_valid", {31'd0, out_valid}, 32'd0);
      // async reset while HELD
      cyc(1'b1, 32'h500, mk(1, 2, 3), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      #1 chk("t7_async_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      // randomized traffic with bypass-prone register indices
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] ins;
         ins        = $urandom;
         ins[19:15] = 5'($urandom_range(0, 7));
         ins[24:20] = 5'($urandom_range(0, 7));
         cyc($urandom_range(0, 3) != 0, $urandom, ins, $urandom_range(0, 2) != 0,
             $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
             5'($urandom_range(0, 7)), $urandom);
      end
      repeat (3) idle();
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
